// File: rtl/pcpi_mul_pkg.sv
// pcpi_mul_pkg: shared opcode, funct3 and FSM state definitions for the PCPI multiplier.
package pcpi_mul_pkg;
  localparam logic [6:0] OPC_OP = 7'b0110011;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;
  localparam logic [1:0] F3_MUL = 2'b00;
  localparam logic [1:0] F3_MULH = 2'b01;
  localparam logic [1:0] F3_MULHSU = 2'b10;
  localparam logic [1:0] F3_MULHU = 2'b11;
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
endpackage

// File: rtl/mul_radix4_pp.sv
// mul_radix4_pp: operand times one radix-4 digit (0, A, 2A, 3A).
module mul_radix4_pp #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [1:0]       d,
  output logic [WIDTH+1:0] p
);
  logic [WIDTH+1:0] a1, a2;
  always_comb begin
    a1 = {2'b00, a};
    a2 = {1'b0, a, 1'b0};
    p = d[1] ? (d[0] ? a1 + a2 : a2) : (d[0] ? a1 : '0);
  end
endmodule

// File: rtl/pcpi_mul_seq.sv
// pcpi_mul_seq: sequential radix-4 PCPI multiplier for MUL/MULH/MULHSU/MULHU.
// Define PCPI_MUL_EARLY_EXIT_EN to finish as soon as the remaining multiplier is zero.
module pcpi_mul_seq
  import pcpi_mul_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pcpi_valid,
  input  logic [31:0]      pcpi_insn,
  input  logic [WIDTH-1:0] pcpi_rs1,
  input  logic [WIDTH-1:0] pcpi_rs2,
  output logic             pcpi_wr,
  output logic [WIDTH-1:0] pcpi_rd,
  output logic             pcpi_wait,
  output logic             pcpi_ready
);
  localparam int STEPS = WIDTH / 2;
  localparam int CW = $clog2(STEPS);
  state_t state, state_n;
  logic [WIDTH-1:0] a_q, a_n, b_q, b_n, b_nx, rd_q, rd_n, mag_a, mag_b;
  logic [2*WIDTH-1:0] acc_q, acc_n, step, prod;
  logic [CW-1:0] cnt_q, cnt_n;
  logic [1:0] f3_q, f3_n, f3_in;
  logic [WIDTH+1:0] pp;
  logic neg_q, neg_n, wait_q, wait_n, ready_q, ready_n;
  logic match, sa, sb, na, nb, last, unused;
  assign unused = ^{pcpi_insn[24:15], pcpi_insn[11:7]};
  mul_radix4_pp #(.WIDTH(WIDTH)) u_pp (.a(a_q), .d(b_q[1:0]), .p(pp));
  always_comb begin
    match = pcpi_insn[6:0] == OPC_OP && pcpi_insn[31:25] == F7_MULDIV && !pcpi_insn[14];
    f3_in = pcpi_insn[13:12];
    sa = f3_in != F3_MULHU;
    sb = f3_in == F3_MUL || f3_in == F3_MULH;
    na = sa & pcpi_rs1[WIDTH-1];
    nb = sb & pcpi_rs2[WIDTH-1];
    mag_a = na ? -pcpi_rs1 : pcpi_rs1;
    mag_b = nb ? -pcpi_rs2 : pcpi_rs2;
    step = acc_q + ({{(WIDTH-2){1'b0}}, pp} << {cnt_q, 1'b0});
    b_nx = b_q >> 2;
`ifdef PCPI_MUL_EARLY_EXIT_EN
    last = b_nx == '0 || cnt_q == CW'(STEPS - 1);
`else
    last = cnt_q == CW'(STEPS - 1);
`endif
    prod = neg_q ? -acc_q : acc_q;
  end
  always_comb begin
    state_n = state;
    a_n = a_q;
    b_n = b_q;
    acc_n = acc_q;
    cnt_n = cnt_q;
    neg_n = neg_q;
    f3_n = f3_q;
    rd_n = rd_q;
    wait_n = wait_q;
    ready_n = 1'b0;
    case (state)
      IDLE: if (pcpi_valid && match) begin
        a_n = mag_a;
        b_n = mag_b;
        acc_n = '0;
        cnt_n = '0;
        neg_n = na ^ nb;
        f3_n = f3_in;
        wait_n = 1'b1;
        state_n = CALC;
      end
      CALC: if (!pcpi_valid) begin
        wait_n = 1'b0;
        state_n = IDLE;
      end else begin
        acc_n = step;
        b_n = b_nx;
        cnt_n = cnt_q + CW'(1);
        state_n = last ? FIX : CALC;
      end
      FIX: if (!pcpi_valid) begin
        wait_n = 1'b0;
        state_n = IDLE;
      end else begin
        rd_n = f3_q == F3_MUL ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];
        ready_n = 1'b1;
        wait_n = 1'b0;
        state_n = DONE;
      end
      DONE: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      a_q <= '0;
      b_q <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      neg_q <= 1'b0;
      f3_q <= '0;
      rd_q <= '0;
      wait_q <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state <= state_n;
      a_q <= a_n;
      b_q <= b_n;
      acc_q <= acc_n;
      cnt_q <= cnt_n;
      neg_q <= neg_n;
      f3_q <= f3_n;
      rd_q <= rd_n;
      wait_q <= wait_n;
      ready_q <= ready_n;
    end
  end
  assign pcpi_rd = rd_q;
  assign pcpi_wait = wait_q;
  assign pcpi_ready = ready_q;
  assign pcpi_wr = ready_q;
endmodule

// File: tb/tb_pcpi_mul_seq.sv
// tb_pcpi_mul_seq: random and directed checks of pcpi_mul_seq against a behavioural model.
module tb_pcpi_mul_seq;
  logic clk = 1'b0, reset = 1'b1, pcpi_valid = 1'b0;
  logic [31:0] pcpi_insn = '0, pcpi_rs1 = '0, pcpi_rs2 = '0;
  logic pcpi_wr, pcpi_wait, pcpi_ready;
  logic [31:0] pcpi_rd;
  int tests = 0, fails = 0;
`ifdef PCPI_MUL_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif
  pcpi_mul_seq dut (
    .clk(clk), .reset(reset), .pcpi_valid(pcpi_valid), .pcpi_insn(pcpi_insn),
    .pcpi_rs1(pcpi_rs1), .pcpi_rs2(pcpi_rs2), .pcpi_wr(pcpi_wr), .pcpi_rd(pcpi_rd),
    .pcpi_wait(pcpi_wait), .pcpi_ready(pcpi_ready)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] mk_insn(input logic [2:0] f3);
    return {7'b0000001, 5'd3, 5'd2, f3, 5'd1, 7'b0110011};
  endfunction
  function automatic bit is_match(input logic [31:0] i);
    return i[6:0] == 7'b0110011 && i[31:25] == 7'b0000001 && !i[14];
  endfunction
  function automatic logic [31:0] ref_mul(input logic [1:0] f3, input logic [31:0] a, b);
    logic [63:0] ea, eb, p;
    ea = (f3 != 2'b11 && a[31]) ? {32'hFFFFFFFF, a} : {32'h0, a};
    eb = (f3 <= 2'b01 && b[31]) ? {32'hFFFFFFFF, b} : {32'h0, b};
    p = ea * eb;
    return f3 == 2'b00 ? p[31:0] : p[63:32];
  endfunction
  function automatic int steps_of(input logic [1:0] f3, input logic [31:0] b);
    logic [31:0] m;
    int n;
    if (!EARLY) return 16;
    m = (f3 <= 2'b01 && b[31]) ? -b : b;
    n = 1;
    for (int i = 1; i < 16; i++) if ((m >> (2 * i)) != 0) n = i + 1;
    return n;
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  int ph = 0, k = 0, n = 0;
  logic [31:0] m_exp = '0, m_rd = '0;
  logic m_wait = 1'b0, m_ready = 1'b0;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      ph = 0; k = 0; m_rd = '0; m_wait = 1'b0; m_ready = 1'b0;
    end else begin
      m_ready = 1'b0;
      if (ph == 0) begin
        if (pcpi_valid && is_match(pcpi_insn)) begin
          ph = 1; k = 0; m_wait = 1'b1;
          n = steps_of(pcpi_insn[13:12], pcpi_rs2);
          m_exp = ref_mul(pcpi_insn[13:12], pcpi_rs1, pcpi_rs2);
        end
      end else if (ph == 1) begin
        if (!pcpi_valid) begin
          ph = 0; m_wait = 1'b0;
        end else begin
          k++;
          if (k == n + 1) begin
            m_ready = 1'b1; m_wait = 1'b0; m_rd = m_exp; ph = 2;
          end
        end
      end else ph = 0;
    end
  end
  always @(negedge clk) begin
    chk("wait", {31'b0, pcpi_wait}, {31'b0, m_wait});
    chk("ready", {31'b0, pcpi_ready}, {31'b0, m_ready});
    chk("wr", {31'b0, pcpi_wr}, {31'b0, m_ready});
    chk("rd", pcpi_rd, m_rd);
  end
  task automatic run_op(input logic [1:0] f3, input logic [31:0] a, b, input logic [31:0] exp);
    int cyc;
    bit done;
    @(negedge clk);
    pcpi_valid = 1'b1; pcpi_insn = mk_insn({1'b0, f3}); pcpi_rs1 = a; pcpi_rs2 = b;
    cyc = 0; done = 0;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (pcpi_ready) done = 1;
    end
    if (!done) begin
      tests++; fails++;
      $display("FAIL op_timeout: no ready for f3=%0d a=%h b=%h", f3, a, b);
    end else begin
      chk("op_rd", pcpi_rd, exp);
      chk("op_latency", 32'(cyc), 32'(steps_of(f3, b) + 2));
    end
    pcpi_valid = 1'b0;
  endtask
  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h80000000;
      2: return 32'hFFFFFFFF;
      3: return 32'h1;
      4: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction
  initial begin
    logic seen;
    logic [1:0] f3;
    logic [31:0] a, b;
    repeat (2) @(negedge clk);
    chk("rst_rd", pcpi_rd, 32'h0);
    chk("rst_wait", {31'b0, pcpi_wait}, 32'h0);
    chk("rst_ready", {31'b0, pcpi_ready}, 32'h0);
    chk("rst_wr", {31'b0, pcpi_wr}, 32'h0);
    reset = 1'b0;
    run_op(2'b00, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB);
    run_op(2'b01, 32'h80000000, 32'h80000000, 32'h40000000);
    run_op(2'b01, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF);
    run_op(2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
    run_op(2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
    run_op(2'b11, 32'h12345678, 32'h00000003, 32'h00000000);
    run_op(2'b00, 32'h12345678, 32'h00000003, 32'h369D0368);
    @(negedge clk);
    pcpi_valid = 1'b1; pcpi_insn = mk_insn(3'b100); pcpi_rs1 = 32'd100; pcpi_rs2 = 32'd7;
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      seen |= pcpi_wait | pcpi_ready | pcpi_wr;
    end
    chk("div_silent", {31'b0, seen}, 32'h0);
    pcpi_valid = 1'b0;
    @(negedge clk);
    pcpi_valid = 1'b1; pcpi_insn = mk_insn(3'b011); pcpi_rs1 = 32'hDEADBEEF; pcpi_rs2 = 32'hCAFEF00D;
    repeat (5) @(negedge clk);
    pcpi_valid = 1'b0;
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      seen |= pcpi_ready | pcpi_wr;
    end
    chk("abort_no_ready", {31'b0, seen}, 32'h0);
    chk("abort_wait", {31'b0, pcpi_wait}, 32'h0);
    pcpi_valid = 1'b1; pcpi_insn = mk_insn(3'b001); pcpi_rs1 = 32'h7FFFFFFF; pcpi_rs2 = 32'h80000001;
    repeat (8) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_wait", {31'b0, pcpi_wait}, 32'h0);
    chk("mid_rst_ready", {31'b0, pcpi_ready}, 32'h0);
    chk("mid_rst_rd", pcpi_rd, 32'h0);
    @(negedge clk);
    reset = 1'b0; pcpi_valid = 1'b0;
    run_op(2'b01, 32'h7FFFFFFF, 32'h80000001, 32'hC0000000);
    repeat (40) begin
      f3 = 2'($urandom_range(0, 3));
      a = pick();
      b = pick();
      run_op(f3, a, b, ref_mul(f3, a, b));
    end
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/pcpi_mul_seq.md
Name: pcpi_mul_seq

Overview:
Sequential PicoRV32 PCPI co-processor front end for the RV32M multiply group (MUL, MULH, MULHSU, MULHU).
- Decodes the instruction and accepts rs1/rs2.
- Converts operands to magnitudes and runs an iterative radix-4 shift-add multiply, 2 multiplier bits per cycle (16 steps).
- Applies the sign fix, selects the result half and returns it over the PCPI handshake.
- Sits directly between the CPU's PCPI port and the team's radix-4 partial-product multiply datapath.

Parameters:
WIDTH, 32, operand width; only 32 is supported for PCPI; product is 2*WIDTH.
STEPS, WIDTH/2, localparam; radix-4 iterations; counter width $clog2(STEPS).

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
pcpi_valid  input  1  CPU request valid
pcpi_insn  input  32  instruction word
pcpi_rs1  input  32  operand A
pcpi_rs2  input  32  operand B
pcpi_wr  output  1  result write enable, pulses with pcpi_ready
pcpi_rd  output  32  result
pcpi_wait  output  1  request accepted, result pending
pcpi_ready  output  1  result valid, one-cycle pulse

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-high.
- Reset: all outputs 0, state IDLE, accumulator/operands/counter 0.
- Reset asserted mid-operation aborts immediately; no ready is produced.
- Decode match requires all of: insn[6:0]=0110011, insn[31:25]=0000001, insn[14]=0.
- funct3=insn[13:12]: 00 MUL (low half), 01 MULH (s×s), 10 MULHSU (s×u), 11 MULHU (u×u).
- Non-matching insn: block stays silent (wait/ready/wr stay 0).
- States: IDLE, CALC, FIX, DONE.
- IDLE: on pcpi_valid & match at edge E0:
  - latch |rs1|, |rs2| per the signedness of funct3; -2^31 gives magnitude 0x80000000.
  - latch neg = signA^signB (signs forced to 0 for unsigned operands); latch funct3.
  - clear accumulator, count=0, pcpi_wait<=1, go to CALC.
- CALC: each edge, acc += ({32'b0,A} * B[1:0]) << (2*count); B >>= 2; count++. After the count=STEPS-1 step, go to FIX (at E16).
- FIX at E17:
  - P = neg ? -acc : acc (64-bit two's complement).
  - pcpi_rd <= (funct3==00) ? P[31:0] : P[63:32].
  - pcpi_ready<=1, pcpi_wr<=1, pcpi_wait<=0; go to DONE.
- Latency: pcpi_ready high exactly one cycle, E17→E18.
- DONE: pcpi_valid ignored; at E18 clear ready/wr and go to IDLE; pcpi_rd holds its value until the next FIX.
- Abort: pcpi_valid low in CALC or FIX → IDLE next edge, wait cleared, no ready/wr.
- Back-to-back: next request accepted no earlier than E19 (IDLE sees valid).
- All arithmetic is unsigned modulo 2^64; no overflow flag.

Optional Feature:
PCPI_MUL_EARLY_EXIT_EN
- Defined: in CALC, when the B value remaining after the current step is zero, go to FIX next. Latency = 1 + number of 2-bit digits up to the most significant non-zero digit of |rs2| (minimum 1 step), i.e. ready at E(n+1).
- Undefined: fixed 16 steps, ready at E17.
- Results are identical in both builds.

Decomposition:
- Package pcpi_mul_pkg:
  - OPC_OP=7'b0110011, F7_MULDIV=7'b0000001.
  - funct3 constants F3_MUL/F3_MULH/F3_MULHSU/F3_MULHU.
  - state enum {IDLE, CALC, FIX, DONE}.
- Sub-module mul_radix4_pp: combinational 32-bit × 2-bit digit → 34-bit partial product (0, A, 2A, 3A), instantiated once in the CALC datapath.

Test Plan:
- MUL rs1=0x00000007, rs2=0xFFFFFFFD → pcpi_rd=0xFFFFFFEB, wr=ready=1 for one cycle at E17; wait high E1..E16 and low from E17.
- MULH 0x80000000×0x80000000 → 0x40000000; MULH 0xFFFFFFFF×0x00000001 → 0xFFFFFFFF.
- MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF; MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
- DIV insn (funct3=100) held valid 20 cycles → wait/ready/wr stay 0.
- Drop valid at E5 → no ready, IDLE at E6. Assert reset at E8 of a second op → all outputs 0 immediately; next op completes normally.
- With PCPI_MUL_EARLY_EXIT_EN: MULHU rs1=0x12345678, rs2=0x00000003 → pcpi_rd=0x00000000, ready at E2. MUL same operands → 0x369D0368, ready at E2. Without the macro: same results at E17.
